osc_freq_counter: RTL and testbench

User-design core that sits behind the 12-pin fabric IO wrapper, consuming io_in and driving io_out/io_oeb.
- Counts rising edges of an external oscillator on io_in[0] over a fixed gate window of clk cycles.
- Latches the count and streams it MSB-byte-first as 8N1 UART on io_out[2].
- Serves as the on-fabric measurement block for ring-oscillator/clock characterisation.

---
 rtl/osc_freq_counter.sv | 219 +++++++++++++++++++++
 tb/tb_osc_freq_counter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/osc_freq_counter.sv
// osc_freq_counter: counts rising edges of an external oscillator (io_in[0])
// over a fixed gate window of clk cycles, then reports the count as 8N1 UART
// bytes, most significant byte first, on io_out[2].
// Optional build macro OSC_HEADER_EN: each report is prefixed with a 0xA5
// header byte and a flags byte {7'b0, overflow}.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for synced enable
// S_GATE  | counting oscillator edges for GATE_CYCLES clk cycles
// S_LATCH | one cycle: copy count into the TX shift register
// S_TX    | shifting out the report bytes, 8N1, back-to-back
module osc_freq_counter #(
    parameter int GATE_CYCLES  = 1000000,
    parameter int CNT_WIDTH    = 24,
    parameter int CLKS_PER_BIT = 104,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] io_in,
    output logic [11:0] io_out,
    output logic [11:0] io_oeb
);

`ifdef OSC_HEADER_EN
    localparam int NBYTES = CNT_WIDTH / 8 + 2;
`else
    localparam int NBYTES = CNT_WIDTH / 8;
`endif
    localparam int SHW = NBYTES * 8;
    localparam int GW  = $clog2(GATE_CYCLES);
    localparam int TW  = $clog2(CLKS_PER_BIT);
    localparam int BW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GATE, S_LATCH, S_TX} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_osc_sync;
    logic [SYNC_STAGES-1:0] r_en_sync;
    logic                   r_osc_prev;
    logic [GW-1:0]          r_gate_cnt;
    logic [CNT_WIDTH-1:0]   r_edge_cnt;
    logic                   r_ovf;
    logic                   r_ovf_out;
    logic [SHW-1:0]         r_shift;
    logic [TW-1:0]          r_bit_tmr;
    logic [3:0]             r_bit_idx;
    logic [BW-1:0]          r_byte_idx;

    logic                   w_osc;
    logic                   w_en;
    logic                   w_rise;
    logic                   w_sat;
    logic                   w_ovf_nxt;
    logic                   w_gate_last;
    logic                   w_tx_last;
    logic                   w_gate_start;
    logic                   w_busy;
    logic                   w_tx;
    logic [7:0]             w_cur_byte;
    logic [SHW-1:0]         w_load;
    logic                   w_unused_io;

    assign w_osc       = r_osc_sync[SYNC_STAGES-1];
    assign w_en        = r_en_sync[SYNC_STAGES-1];
    assign w_rise      = w_osc & ~r_osc_prev;
    assign w_sat       = &r_edge_cnt;
    assign w_ovf_nxt   = r_ovf | (w_rise & w_sat);
    assign w_gate_last = (r_gate_cnt == GW'(GATE_CYCLES - 1));
    assign w_tx_last   = (r_bit_tmr == '0) && (r_bit_idx == 4'd9) &&
                         (r_byte_idx == BW'(NBYTES - 1));
    assign w_cur_byte  = r_shift[SHW-1 -: 8];
    assign w_busy      = (r_state != S_IDLE);
    assign w_unused_io = ^io_in[11:2];

`ifdef OSC_HEADER_EN
    assign w_load = {8'hA5, 7'b0, r_ovf, r_edge_cnt};
`else
    assign w_load = r_edge_cnt;
`endif

    assign io_out = {7'b0, r_ovf_out, w_busy, w_tx, 2'b00};
    assign io_oeb = 12'h003;

    // Synchronise osc and enable pins; keep previous synced osc for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_osc_sync <= '0;
            r_en_sync  <= '0;
            r_osc_prev <= 1'b0;
        end else begin
            r_osc_sync <= {r_osc_sync[SYNC_STAGES-2:0], io_in[0]};
            r_en_sync  <= {r_en_sync[SYNC_STAGES-2:0], io_in[1]};
            r_osc_prev <= w_osc;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort on enable loss takes priority over gate completion.
    always_comb begin
        w_state_nxt  = r_state;
        w_gate_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_en) begin
                    w_state_nxt  = S_GATE;
                    w_gate_start = 1'b1;
                end
            end
            S_GATE: begin
                if (!w_en) begin
                    w_state_nxt = S_IDLE;
                end else if (w_gate_last) begin
                    w_state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                w_state_nxt = S_TX;
            end
            S_TX: begin
                if (w_tx_last) begin
                    if (w_en) begin
                        w_state_nxt  = S_GATE;
                        w_gate_start = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Gate/edge counting, overflow tracking and UART bit/byte sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
            r_ovf_out  <= 1'b0;
            r_shift    <= '0;
            r_bit_tmr  <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
        end else if (w_gate_start) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
            r_ovf_out  <= 1'b0;
        end else begin
            case (r_state)
                S_GATE: begin
                    r_gate_cnt <= r_gate_cnt + 1'b1;
                    if (w_rise && !w_sat) begin
                        r_edge_cnt <= r_edge_cnt + 1'b1;
                    end
                    if (!w_en) begin
                        r_ovf <= 1'b0;
                    end else begin
                        r_ovf <= w_ovf_nxt;
                        // Publish overflow as the window closes so it is valid in LATCH.
                        if (w_gate_last) begin
                            r_ovf_out <= w_ovf_nxt;
                        end
                    end
                end
                S_LATCH: begin
                    r_shift    <= w_load;
                    r_bit_tmr  <= TW'(CLKS_PER_BIT - 1);
                    r_bit_idx  <= '0;
                    r_byte_idx <= '0;
                end
                S_TX: begin
                    if (r_bit_tmr == '0) begin
                        r_bit_tmr <= TW'(CLKS_PER_BIT - 1);
                        if (r_bit_idx == 4'd9) begin
                            r_bit_idx  <= '0;
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_shift    <= r_shift << 8;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_bit_tmr <= r_bit_tmr - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Line level: idle high, start bit low, data LSB first, stop bit high.
    always_comb begin
        w_tx = 1'b1;
        if (r_state == S_TX) begin
            if (r_bit_idx == 4'd0) begin
                w_tx = 1'b0;
            end else if (r_bit_idx == 4'd9) begin
                w_tx = 1'b1;
            end else begin
                w_tx = w_cur_byte[3'(r_bit_idx - 4'd1)];
            end
        end
    end

endmodule

// File: tb/tb_osc_freq_counter.sv
// Self-checking bench for osc_freq_counter: per-cycle io_out/io_oeb compared
// against a window-level reference model built from pin-level stimulus.
module tb_osc_freq_counter;
    localparam int CPB  = 4;
    localparam int MAXC = 2400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] io_in;
    logic [11:0] out_a, oeb_a, out_b, oeb_b;

    bit          osc_pin [MAXC];
    bit          en_pin  [MAXC];
    logic [11:0] exp_out [MAXC];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    osc_freq_counter #(.GATE_CYCLES(100), .CNT_WIDTH(16), .CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .io_in(io_in), .io_out(out_a), .io_oeb(oeb_a)
    );

    osc_freq_counter #(.GATE_CYCLES(2000), .CNT_WIDTH(8), .CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .io_in(io_in), .io_out(out_b), .io_oeb(oeb_b)
    );

    task automatic check_val(input string tag, input int cyc, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit osc_at(input int k);
        return (k < 0 || k >= MAXC) ? 1'b0 : osc_pin[k];
    endfunction

    function automatic bit en_at(input int k);
        return (k < 0 || k >= MAXC) ? 1'b0 : en_pin[k];
    endfunction

    // Reference: enable seen SYNC+1 cycles after the pin; a gate of g cycles
    // counts pin rises landing inside it (pin-to-count latency SYNC+1); then one
    // LATCH cycle and the UART frames; continuous if enable still high at the end.
    task automatic build_expect(input int g, input int cw, input int n);
        int c, s, abort_k, edges, maxv, cnt, t_len, last, j, bit_n, bi;
        bit ov, ovf_hold, tx;
        logic [7:0] q[$];
        for (int k = 0; k < n; k++) exp_out[k] = 12'h004;
        c = 0; s = -1; ovf_hold = 1'b0;
        while (c < n) begin
            if (s < 0) begin
                exp_out[c] = {7'b0, ovf_hold, 1'b0, 1'b1, 2'b00};
                if (en_at(c - 2)) s = c + 1;
                c++;
            end else begin
                abort_k = -1;
                for (int k = s; k < s + g; k++) begin
                    if (!en_at(k - 2)) begin
                        abort_k = k;
                        break;
                    end
                end
                if (abort_k >= 0) begin
                    for (int k = s; k <= abort_k && k < n; k++) exp_out[k] = 12'h00C;
                    ovf_hold = 1'b0;
                    c = abort_k + 1;
                    s = -1;
                end else begin
                    edges = 0;
                    for (int k = s - 2; k <= s + g - 3; k++)
                        if (osc_at(k) && !osc_at(k - 1)) edges++;
                    maxv = (1 << cw) - 1;
                    ov   = (edges > maxv);
                    cnt  = ov ? maxv : edges;
                    q.delete();
`ifdef OSC_HEADER_EN
                    q.push_back(8'hA5);
                    q.push_back({7'b0, ov});
`endif
                    for (int i = cw / 8 - 1; i >= 0; i--) q.push_back(8'(cnt >> (8 * i)));
                    t_len = q.size() * 10 * CPB;
                    last  = s + g + t_len;
                    for (int k = s; k <= last && k < n; k++) begin
                        tx = 1'b1;
                        if (k > s + g) begin
                            j     = k - (s + g + 1);
                            bit_n = j / CPB;
                            bi    = bit_n % 10;
                            if (bi == 0) tx = 1'b0;
                            else if (bi < 9) tx = q[bit_n / 10][bi - 1];
                        end
                        exp_out[k] = {7'b0, (k >= s + g) ? ov : 1'b0, 1'b1, tx, 2'b00};
                    end
                    ovf_hold = ov;
                    c = last + 1;
                    s = en_at(last - 2) ? last + 1 : -1;
                end
            end
        end
    endtask

    task automatic fill_osc_period(input int p, input int ph, input int n);
        for (int c = 0; c < n; c++) osc_pin[c] = (((c + ph) % p) < (p / 2));
    endtask

    task automatic fill_osc_random(input int n);
        int c, len;
        bit v;
        c = 0;
        v = 1'($urandom_range(0, 1));
        while (c < n) begin
            len = $urandom_range(1, 5);
            for (int i = 0; i < len && c < n; i++) begin
                osc_pin[c] = v;
                c++;
            end
            v = !v;
        end
    endtask

    task automatic clear_en(input int n);
        for (int c = 0; c < n; c++) en_pin[c] = 1'b0;
    endtask

    task automatic set_en(input int on, input int off, input int n);
        for (int c = on; c < off && c < n; c++) en_pin[c] = 1'b1;
    endtask

    task automatic run_scn(input string tag, input int sel, input int n, input int rst_at);
        logic [11:0] go, gb;
        build_expect(sel ? 2000 : 100, sel ? 8 : 16, n);
        @(posedge clk); #1;
        rst_n = 1'b0;
        io_in = '0;
        @(posedge clk); #1;
        go = sel ? out_b : out_a;
        check_val({tag, "_rst_out"}, -1, {20'b0, go}, 32'h004);
        check_val({tag, "_rst_oeb"}, -1, {8'b0, oeb_a, oeb_b}, 32'h003003);
        @(posedge clk); #1;
        for (int c = 0; c < n; c++) begin
            if (n_fail > 40) break;
            go = sel ? out_b : out_a;
            gb = sel ? oeb_b : oeb_a;
            check_val(tag, c, {8'b0, gb, go}, {8'b0, 12'h003, exp_out[c]});
            if (c == 0) rst_n = 1'b1;
            io_in = {10'b0, en_pin[c], osc_pin[c]};
            if (c == rst_at) begin
                #3 rst_n = 1'b0;
                #1;
                go = sel ? out_b : out_a;
                gb = sel ? oeb_b : oeb_a;
                check_val({tag, "_async_rst"}, c, {8'b0, gb, go}, {8'b0, 12'h003, 12'h004});
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        int e, s, n, t_len, on, off, c;
        rst_n = 1'b0;
        io_in = '0;
`ifdef OSC_HEADER_EN
        t_len = 4 * 10 * CPB;
`else
        t_len = 2 * 10 * CPB;
`endif

        // basic count, one window then enable dropped during TX
        e = $urandom_range(2, 6); s = e + 3; n = s + 100 + t_len + 60;
        fill_osc_period(10, $urandom_range(0, 9), n);
        clear_en(n); set_en(e, s + 140, n);
        run_scn("basic", 0, n, -1);

        // saturation on 8-bit counter, then a second gate entry clears overflow
        e = $urandom_range(2, 6); s = e + 3; n = s + 2200;
        fill_osc_period(4, $urandom_range(0, 3), n);
        clear_en(n); set_en(e, s + 2010, n); set_en(s + 2100 + (t_len - 40), n, n);
        run_scn("sat", 1, n, -1);

        // abort at gate cycle 50, then a fresh full window
        e = $urandom_range(2, 6); s = e + 3; n = s + 80 + 100 + t_len + 80;
        fill_osc_period(10, $urandom_range(0, 9), n);
        clear_en(n); set_en(e, s + 50, n); set_en(s + 80, s + 80 + 140 + (t_len - 80), n);
        run_scn("abort", 0, n, -1);

        // continuous mode, enable held high
        e = $urandom_range(2, 6); n = e + 3 * (101 + t_len) + 30;
        fill_osc_period(5, $urandom_range(0, 4), n);
        clear_en(n); set_en(e, n, n);
        run_scn("cont", 0, n, -1);

        // reset pulse during the 3rd data bit of the first byte
        e = $urandom_range(2, 6); s = e + 3; n = s + 400;
        fill_osc_period(10, $urandom_range(0, 9), n);
        clear_en(n); set_en(e, s + 140 + (t_len - 80), n);
        run_scn("rst_tx", 0, n, s + 100 + 1 + 3 * CPB + 1);

        // randomized oscillator and enable patterns
        for (int it = 0; it < 4; it++) begin
            n = 700;
            fill_osc_random(n);
            clear_en(n);
            c = $urandom_range(2, 10);
            while (c < n) begin
                on  = c;
                off = on + $urandom_range(20, 260);
                set_en(on, off, n);
                c = off + $urandom_range(3, 60);
            end
            run_scn("rand", 0, n, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
